// File: rtl/uart_2_apb_if.sv
// uart_2_apb_if: APB bus bundle between the UART-driven APB master and a
// responder.
//   master modport: drives paddr, pprot, psel, penable, pwrite, pwdata and
//                   pstrb; receives pready, prdata and pslverr.
//   slave modport : the mirror image of the master modport.
interface uart_2_apb_if;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/uart_2_apb.sv
// uart_2_apb: UART-controlled APB master (host/debug bridge).
// The block receives 8N1 command frames on rx, issues one APB read or write
// per frame, and returns a status byte (plus read data) on tx.
//   Write frame: 0x57, A3..A0, D3..D0   -> response 0x06 / 0x15
//   Read frame : 0x52, A3..A0           -> response status, D3..D0
// Ports:
//   clk    system clock
//   arstn  asynchronous active-low reset
//   rx     serial input from the host
//   tx     serial output to the host (idles high)
//   apb    APB master port (uart_2_apb_if.master)
//   busy   high from the accepted command byte until the response is sent
// Optional build macro UART2APB_TIMEOUT_EN: when defined, an ACCESS phase
// that sees no pready for TIMEOUT_CYCLES cycles is abandoned and answered
// with NAK (read data bytes 0x00). When undefined, ACCESS waits forever.
module uart_2_apb #(
  parameter int baudrate       = 9600,
  parameter int clk_frec       = 100000000,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              rx,
  output logic              tx,
  uart_2_apb_if.master      apb,
  output logic              busy
);

  localparam int BIT_CYC = clk_frec / baudrate;
  localparam int CW      = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((BIT_CYC / 2) - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_SETUP, ST_ACCESS, ST_RESP} st_t;

  // Response byte selector: index 1..4 walks the read data MSB first.
  function automatic logic [7:0] resp_byte(input logic [2:0] idx, input logic [31:0] d);
    case (idx)
      3'd1:    resp_byte = d[31:24];
      3'd2:    resp_byte = d[23:16];
      3'd3:    resp_byte = d[15:8];
      default: resp_byte = d[7:0];
    endcase
  endfunction

  // Receiver state
  logic            rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t       rx_state_r, rx_nxt_s;
  logic [CW-1:0]   rx_cnt_r;
  logic [2:0]      rx_bit_r;
  logic [7:0]      rx_shift_r;
  logic            rx_fall_s, rx_done_s, rx_ferr_s;

  // Command / APB state
  st_t             st_r, st_nxt_s;
  logic            is_wr_r;
  logic [1:0]      byte_cnt_r;
  logic [31:0]     addr_sh_r;
  logic [23:0]     data_sh_r;
  logic [31:0]     paddr_r, pwdata_r, rdata_r;
  logic [3:0]      pstrb_r;
  logic            psel_r, penable_r, pwrite_r, busy_r;
  logic            acc_done_s, acc_err_s;

  // Transmitter state
  logic            tx_r;
  logic [8:0]      tx_sh_r;
  logic [CW-1:0]   tx_cnt_r;
  logic [3:0]      tx_bit_r;
  logic [2:0]      tx_idx_r;
  logic            tx_bit_end_s, tx_last_s;

`ifdef UART2APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]   to_cnt_r;
`endif

  assign rx_fall_s    = rx_prev_r & ~rx_sync_r;
  assign tx_bit_end_s = (st_r == ST_RESP) && (tx_cnt_r == BIT_LAST);
  // Bit 9 is the stop bit; the last byte is index 0 (write) or 4 (read).
  assign tx_last_s    = tx_bit_end_s && (tx_bit_r == 4'd9) &&
                        (tx_idx_r == (is_wr_r ? 3'd0 : 3'd4));

  // Receiver next-state and byte/framing-error strobes.
  always_comb begin
    rx_nxt_s  = rx_state_r;
    rx_done_s = 1'b0;
    rx_ferr_s = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (rx_fall_s) rx_nxt_s = RX_START;
        else           rx_nxt_s = RX_IDLE;
      end
      RX_START: begin
        // Mid-start check: a high line here was a glitch, not a start bit.
        if (rx_cnt_r == HALF_LAST) rx_nxt_s = rx_sync_r ? RX_IDLE : RX_DATA;
        else                       rx_nxt_s = RX_START;
      end
      RX_DATA: begin
        if ((rx_cnt_r == BIT_LAST) && (rx_bit_r == 3'd7)) rx_nxt_s = RX_STOP;
        else                                             rx_nxt_s = RX_DATA;
      end
      RX_STOP: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_nxt_s  = RX_IDLE;
          rx_done_s = rx_sync_r;
          rx_ferr_s = ~rx_sync_r;
        end else begin
          rx_nxt_s = RX_STOP;
        end
      end
      default: rx_nxt_s = RX_IDLE;
    endcase
  end

  // Receiver synchronizer, state register, bit timer and shift register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_prev_r  <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= '0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
    end else begin
      rx_meta_r  <= rx;
      rx_sync_r  <= rx_meta_r;
      rx_prev_r  <= rx_sync_r;
      rx_state_r <= rx_nxt_s;
      case (rx_state_r)
        RX_IDLE: begin
          rx_cnt_r <= '0;
          rx_bit_r <= 3'd0;
        end
        RX_START: rx_cnt_r <= (rx_cnt_r == HALF_LAST) ? '0 : rx_cnt_r + CW'(1);
        RX_DATA: begin
          if (rx_cnt_r == BIT_LAST) begin
            rx_cnt_r   <= '0;
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            rx_bit_r   <= rx_bit_r + 3'd1;
          end else begin
            rx_cnt_r <= rx_cnt_r + CW'(1);
          end
        end
        RX_STOP: rx_cnt_r <= (rx_cnt_r == BIT_LAST) ? '0 : rx_cnt_r + CW'(1);
        default: rx_cnt_r <= '0;
      endcase
    end
  end

  // Command FSM next-state; bytes arriving outside IDLE/ADDR/DATA are dropped.
  always_comb begin
    st_nxt_s   = st_r;
    acc_done_s = 1'b0;
    acc_err_s  = 1'b0;
    case (st_r)
      ST_IDLE: begin
        if (rx_done_s && ((rx_shift_r == 8'h57) || (rx_shift_r == 8'h52))) st_nxt_s = ST_ADDR;
        else                                                               st_nxt_s = ST_IDLE;
      end
      ST_ADDR: begin
        if (rx_ferr_s)                                st_nxt_s = ST_IDLE;
        else if (rx_done_s && (byte_cnt_r == 2'd3))   st_nxt_s = is_wr_r ? ST_DATA : ST_SETUP;
        else                                          st_nxt_s = ST_ADDR;
      end
      ST_DATA: begin
        if (rx_ferr_s)                                st_nxt_s = ST_IDLE;
        else if (rx_done_s && (byte_cnt_r == 2'd3))   st_nxt_s = ST_SETUP;
        else                                          st_nxt_s = ST_DATA;
      end
      ST_SETUP: st_nxt_s = ST_ACCESS;
      ST_ACCESS: begin
        if (apb.pready) begin
          st_nxt_s   = ST_RESP;
          acc_done_s = 1'b1;
          acc_err_s  = apb.pslverr;
        end
`ifdef UART2APB_TIMEOUT_EN
        else if (to_cnt_r == TO_LAST) begin
          st_nxt_s   = ST_RESP;
          acc_done_s = 1'b1;
          acc_err_s  = 1'b1;
        end
`endif
        else begin
          st_nxt_s = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (tx_last_s) st_nxt_s = ST_IDLE;
        else           st_nxt_s = ST_RESP;
      end
      default: st_nxt_s = ST_IDLE;
    endcase
  end

  // Command state register, frame assembly and APB output registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      st_r       <= ST_IDLE;
      is_wr_r    <= 1'b0;
      byte_cnt_r <= 2'd0;
      addr_sh_r  <= 32'h0;
      data_sh_r  <= 24'h0;
      paddr_r    <= 32'h0;
      pwdata_r   <= 32'h0;
      pstrb_r    <= 4'h0;
      pwrite_r   <= 1'b0;
      psel_r     <= 1'b0;
      penable_r  <= 1'b0;
      busy_r     <= 1'b0;
      rdata_r    <= 32'h0;
    end else begin
      st_r      <= st_nxt_s;
      busy_r    <= (st_nxt_s != ST_IDLE);
      psel_r    <= (st_nxt_s == ST_SETUP) || (st_nxt_s == ST_ACCESS);
      penable_r <= (st_nxt_s == ST_ACCESS);
      if ((st_r == ST_IDLE) && (st_nxt_s == ST_ADDR)) begin
        is_wr_r    <= (rx_shift_r == 8'h57);
        byte_cnt_r <= 2'd0;
      end else if (rx_done_s && (st_r == ST_ADDR)) begin
        addr_sh_r  <= {addr_sh_r[23:0], rx_shift_r};
        byte_cnt_r <= byte_cnt_r + 2'd1;
      end else if (rx_done_s && (st_r == ST_DATA)) begin
        data_sh_r  <= {data_sh_r[15:0], rx_shift_r};
        byte_cnt_r <= byte_cnt_r + 2'd1;
      end else begin
        byte_cnt_r <= byte_cnt_r;
      end
      // The last command byte lands on the same edge SETUP starts, so merge
      // it into the bus value directly instead of waiting for the shifter.
      if (st_nxt_s == ST_SETUP) begin
        paddr_r  <= (st_r == ST_ADDR) ? {addr_sh_r[23:0], rx_shift_r} : addr_sh_r;
        pwdata_r <= is_wr_r ? {data_sh_r, rx_shift_r} : 32'h0;
        pwrite_r <= is_wr_r;
        pstrb_r  <= is_wr_r ? 4'hF : 4'h0;
      end
      if (acc_done_s) begin
        rdata_r <= apb.pready ? apb.prdata : 32'h0;
      end
    end
  end

`ifdef UART2APB_TIMEOUT_EN
  // ACCESS-phase cycle counter for the pready timeout.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)                to_cnt_r <= '0;
    else if (st_r == ST_ACCESS) to_cnt_r <= to_cnt_r + TW'(1);
    else                       to_cnt_r <= '0;
  end
`endif

  // Response transmitter: status byte, then read data, back to back.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tx_r     <= 1'b1;
      tx_sh_r  <= 9'h1FF;
      tx_cnt_r <= '0;
      tx_bit_r <= 4'd0;
      tx_idx_r <= 3'd0;
    end else if (acc_done_s) begin
      tx_r     <= 1'b0;
      tx_sh_r  <= {1'b1, (acc_err_s ? 8'h15 : 8'h06)};
      tx_cnt_r <= '0;
      tx_bit_r <= 4'd0;
      tx_idx_r <= 3'd0;
    end else if (tx_bit_end_s) begin
      tx_cnt_r <= '0;
      if (tx_bit_r == 4'd9) begin
        if (tx_last_s) begin
          tx_r <= 1'b1;
        end else begin
          tx_r     <= 1'b0;
          tx_sh_r  <= {1'b1, resp_byte(tx_idx_r + 3'd1, rdata_r)};
          tx_idx_r <= tx_idx_r + 3'd1;
          tx_bit_r <= 4'd0;
        end
      end else begin
        tx_r     <= tx_sh_r[0];
        tx_sh_r  <= {1'b1, tx_sh_r[8:1]};
        tx_bit_r <= tx_bit_r + 4'd1;
      end
    end else if (st_r == ST_RESP) begin
      tx_cnt_r <= tx_cnt_r + CW'(1);
    end else begin
      tx_r     <= 1'b1;
      tx_cnt_r <= '0;
    end
  end

  assign tx          = tx_r;
  assign busy        = busy_r;
  assign apb.paddr   = paddr_r;
  assign apb.pprot   = 3'b000;
  assign apb.psel    = psel_r;
  assign apb.penable = penable_r;
  assign apb.pwrite  = pwrite_r;
  assign apb.pwdata  = pwdata_r;
  assign apb.pstrb   = pstrb_r;

endmodule

// File: tb/tb_uart_2_apb.sv
// tb_uart_2_apb: self-checking bench for uart_2_apb. A behavioural APB
// responder and a UART byte decoder observe the DUT; expected APB transfers
// and response bytes are derived from the command frames the bench sends.
module tb_uart_2_apb;
  localparam int BAUD    = 9600;
  localparam int CLK_F   = 76800;
  localparam int BIT_CYC = CLK_F / BAUD;
  localparam int TO_CYC  = 16;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic rx = 1'b1;
  logic tx, busy;

  uart_2_apb_if apb_bus();

  uart_2_apb #(.baudrate(BAUD), .clk_frec(CLK_F), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk   (clk),
    .arstn (arstn),
    .rx    (rx),
    .tx    (tx),
    .apb   (apb_bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          setup_n;
    int          acc_n;
    int          unstable;
  } xfer_t;

  xfer_t       xq[$];
  logic [7:0]  txq[$];
  logic [7:0]  exp_q[$];
  int          stop_err = 0;

  int          cfg_waits = 0;
  logic        cfg_hang  = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;
  logic        cfg_err   = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // APB responder and transfer monitor (samples on the falling edge).
  initial begin
    xfer_t cur;
    bit    in_x;
    int    wcnt;
    in_x = 0;
    wcnt = 0;
    cur  = '{32'h0, 1'b0, 32'h0, 4'h0, 0, 0, 0};
    apb_bus.pready  = 1'b0;
    apb_bus.prdata  = 32'h0;
    apb_bus.pslverr = 1'b0;
    forever begin
      @(negedge clk);
      if (apb_bus.psel === 1'b1) begin
        if (!in_x) begin
          in_x = 1;
          cur  = '{apb_bus.paddr, apb_bus.pwrite, apb_bus.pwdata, apb_bus.pstrb, 0, 0, 0};
        end
        if (apb_bus.penable === 1'b1) cur.acc_n++;
        else                          cur.setup_n++;
        if (apb_bus.paddr !== cur.addr || apb_bus.pwrite !== cur.wr ||
            apb_bus.pwdata !== cur.wdata || apb_bus.pstrb !== cur.strb)
          cur.unstable++;
      end else if (in_x) begin
        in_x = 0;
        xq.push_back(cur);
      end
      if (apb_bus.psel === 1'b1 && apb_bus.penable === 1'b1 && !cfg_hang && wcnt >= cfg_waits) begin
        apb_bus.pready  = 1'b1;
        apb_bus.prdata  = cfg_rdata;
        apb_bus.pslverr = cfg_err;
      end else begin
        apb_bus.pready  = 1'b0;
        apb_bus.prdata  = 32'h0;
        apb_bus.pslverr = 1'b0;
        if (apb_bus.psel === 1'b1 && apb_bus.penable === 1'b1) wcnt++;
        else                                                   wcnt = 0;
      end
    end
  end

  // UART decoder on tx: mid-bit sampling, bytes pushed to txq.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (BIT_CYC / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CYC) @(negedge clk);
          b[i] = tx;
        end
        repeat (BIT_CYC) @(negedge clk);
        if (tx !== 1'b1) stop_err++;
        txq.push_back(b);
      end
    end
  end

  initial begin
    repeat (90000) @(negedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // Caller is at a falling edge; frame is driven with no leading idle.
  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx = stop_v;
    repeat (BIT_CYC) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    send_byte(wr ? 8'h57 : 8'h52, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8], 1'b1);
    if (wr) for (int i = 3; i >= 0; i--) send_byte(wdata[i*8 +: 8], 1'b1);
  endtask

  task automatic build_exp(input logic wr, input logic err, input logic [31:0] rdata);
    exp_q.delete();
    exp_q.push_back(err ? 8'h15 : 8'h06);
    if (!wr) for (int i = 3; i >= 0; i--) exp_q.push_back(rdata[i*8 +: 8]);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " busy released"}, {31'h0, busy === 1'b0}, 32'h1);
  endtask

  task automatic check_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input int acc);
    check("apb transfer count", xq.size(), 1);
    if (xq.size() > 0) begin
      check("paddr", xq[0].addr, addr);
      check("pwrite", {31'h0, xq[0].wr}, {31'h0, wr});
      check("pstrb", {28'h0, xq[0].strb}, wr ? 32'hF : 32'h0);
      if (wr) check("pwdata", xq[0].wdata, wdata);
      check("setup cycles", xq[0].setup_n, 1);
      check("access cycles", xq[0].acc_n, acc);
      check("bus stability", xq[0].unstable, 0);
    end
  endtask

  task automatic check_resp();
    check("response length", txq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < txq.size()) check($sformatf("response byte %0d", i), {24'h0, txq[i]}, {24'h0, exp_q[i]});
    check("tx stop bits", stop_err, 0);
  endtask

  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic err, input int waits);
    cfg_waits = waits;
    cfg_rdata = rdata;
    cfg_err   = err;
    cfg_hang  = 1'b0;
    build_exp(wr, err, rdata);
    xq.delete();
    txq.delete();
    send_frame(wr, addr, wdata);
    wait_idle(wr ? "write" : "read");
    check_xfer(wr, addr, wdata, waits + 1);
    check_resp();
  endtask

  initial begin
    logic        r_wr, r_err;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [7:0]  junk;
    int          r_waits;

    repeat (3) @(negedge clk);
    check("reset tx", {31'h0, tx}, 32'h1);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset psel", {31'h0, apb_bus.psel}, 32'h0);
    check("reset penable", {31'h0, apb_bus.penable}, 32'h0);
    check("reset pwrite", {31'h0, apb_bus.pwrite}, 32'h0);
    check("reset paddr", apb_bus.paddr, 32'h0);
    check("reset pwdata", apb_bus.pwdata, 32'h0);
    check("reset pstrb", {28'h0, apb_bus.pstrb}, 32'h0);
    check("pprot", {29'h0, apb_bus.pprot}, 32'h0);
    arstn = 1'b1;
    repeat (4) @(negedge clk);

    // Directed: plain write, waited read, erroring write.
    run_cmd(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    run_cmd(1'b0, 32'h0000_0008, 32'h0, 32'h1234_5678, 1'b0, 3);
    run_cmd(1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'h0, 1'b1, 0);
    check("busy after NAK", {31'h0, busy}, 32'h0);

    // Unknown command byte is ignored.
    xq.delete();
    txq.delete();
    send_byte(8'hAA, 1'b1);
    repeat (30 * BIT_CYC) @(negedge clk);
    check("ignored byte busy", {31'h0, busy}, 32'h0);
    check("ignored byte apb", xq.size(), 0);
    check("ignored byte tx", txq.size(), 0);
    run_cmd(1'b0, 32'h0000_0001, 32'h0, 32'hA5C3_0F96, 1'b0, 1);

    // Framing error in the third byte aborts the command.
    xq.delete();
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (2 * BIT_CYC) @(negedge clk);
    check("framing error busy", {31'h0, busy}, 32'h0);
    run_cmd(1'b1, 32'h1000_0020, 32'h0102_0304, 32'h0, 1'b0, 0);

    // Reset in the middle of a command frame.
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    arstn = 1'b0;
    @(negedge clk);
    check("mid reset busy", {31'h0, busy}, 32'h0);
    check("mid reset tx", {31'h0, tx}, 32'h1);
    arstn = 1'b1;
    repeat (4) @(negedge clk);

    // Slave never asserts pready.
    xq.delete();
    txq.delete();
    cfg_hang = 1'b1;
    cfg_err  = 1'b0;
`ifdef UART2APB_TIMEOUT_EN
    build_exp(1'b0, 1'b1, 32'h0);
    cfg_rdata = 32'hFFFF_FFFF;
    send_frame(1'b0, 32'h0000_0040, 32'h0);
    wait_idle("timeout read");
    check_xfer(1'b0, 32'h0000_0040, 32'h0, TO_CYC);
    check_resp();
    cfg_hang = 1'b0;
`else
    send_frame(1'b0, 32'h0000_0040, 32'h0);
    repeat (100) @(negedge clk);
    check("stalled psel", {31'h0, apb_bus.psel}, 32'h1);
    check("stalled penable", {31'h0, apb_bus.penable}, 32'h1);
    check("stalled tx idle", txq.size(), 0);
    cfg_rdata = 32'hCAFE_F00D;
    cfg_waits = 0;
    build_exp(1'b0, 1'b0, 32'hCAFE_F00D);
    cfg_hang  = 1'b0;
    wait_idle("stalled read");
    check("stalled transfer count", xq.size(), 1);
    check_resp();
`endif

    // Randomized commands, back to back, occasionally preceded by junk.
    for (int k = 0; k < 10; k++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_addr  = $urandom;
      r_wdata = $urandom;
      r_rdata = $urandom;
      r_err   = ($urandom_range(0, 5) == 0);
      r_waits = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'h57 || junk == 8'h52) junk = 8'h00;
        send_byte(junk, 1'b1);
      end
      run_cmd(r_wr, r_addr, r_wdata, r_rdata, r_err, r_waits);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
